// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM-subset main FSM with ALU/flag decode, multiplier handshake and undefined-op detection
module mc_control_unit #(
  parameter int EN_MUL = 1,
  parameter int MUL_MAX_CYCLES = 32,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Mul4,
  input  logic                 MulDone,
  output logic [1:0]           FlagW,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulStart,
  output logic                 MulErr,
  output logic                 Undef
);
  localparam int CW = $clog2(MUL_MAX_CYCLES + 1);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, MULSTART = 4'd10,
    MULWAIT = 4'd11, MULWB = 4'd12;
  logic [3:0] state, next, code, cmd;
  logic [CW-1:0] cnt;
  logic is_mul, alu_op, bad, test_op, arith, timeout, fetch_like;
  assign cmd = Funct[4:1];
  assign is_mul = (EN_MUL != 0) && Funct[5:1] == 5'b0 && Mul4 == 4'b1001;
  assign alu_op = state == EXECR || state == EXECI;
  assign test_op = cmd inside {4'b1000, 4'b1001, 4'b1010, 4'b1011};
  assign arith = cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b1011};
  assign timeout = state == MULWAIT && !MulDone && cnt == CW'(MUL_MAX_CYCLES);
  assign fetch_like = state == FETCH || state == DECODE;
  always_comb begin
    code = 4'b0000;
    bad = 1'b0;
    case (cmd)
      4'b0100: code = 4'b0000;
      4'b0010: code = 4'b0001;
      4'b0000: code = 4'b0010;
      4'b1100: code = 4'b0011;
      4'b0001: code = 4'b0100;
      4'b1000: code = 4'b0101;
      4'b1001: code = 4'b0110;
      4'b1010: code = 4'b0111;
      4'b1011: code = 4'b1000;
      4'b1101: code = 4'b1001;
      4'b1110: code = 4'b1010;
      default: bad = 1'b1;
    endcase
  end
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = DECODE;
      DECODE:   next = Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : Op == 2'b11 ? FETCH :
                       is_mul ? MULSTART : Funct[5] ? EXECI : EXECR;
      MEMADR:   next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next = MEMWB;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      MULSTART: next = MULWAIT;
      MULWAIT:  next = MulDone ? MULWB : timeout ? FETCH : MULWAIT;
      default:  next = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= next != MULWAIT ? '0 : state == MULWAIT ? cnt + CW'(1) : CW'(1);
    end
  end
  assign IRWrite = state == FETCH && !reset;
  assign NextPC = state == FETCH && !reset;
  assign RegW = !reset && (state == MEMWB || state == MULWB || (state == ALUWB && !test_op && !bad));
  assign MemW = state == MEMWR && !reset;
  assign MulStart = state == MULSTART && !reset;
  assign MulErr = timeout && !reset;
  assign Undef = !reset && ((state == DECODE && Op == 2'b11) || (alu_op && bad));
  assign PCS = state == BRANCH || (RegW && Rd == 4'b1111);
  assign AdrSrc = state == MEMRD || state == MEMWR;
  assign ResultSrc = (fetch_like || state == BRANCH) ? 2'b10 : state == MEMWB ? 2'b01 :
                     state == MULWB ? 2'b11 : 2'b00;
  assign ALUSrcA = fetch_like ? 2'b01 : 2'b00;
  assign ALUSrcB = fetch_like ? 2'b10 : (state == MEMADR || state == EXECI || state == BRANCH) ? 2'b01 : 2'b00;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01 && !Funct[0], Op == 2'b10};
  assign ALUControl = alu_op ? ALUCTRL_W'(code) : '0;
  assign FlagW = {(alu_op || state == MULWB) && Funct[0], alu_op && Funct[0] && arith};
endmodule
